// File: rtl/fp_mul_arbiter.sv
// Two-requester round-robin front end around a single combinational FP32 multiplier.
// Operands and results are registered; each result carries its requester id.

module floating_point_spmul (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y,
   output logic        u_flow,
   output logic        o_flow
);

   logic [47:0]       prod;
   logic signed [9:0] exp_sum;
   logic              sign;

   // Truncating multiply; a zero exponent field is treated as zero.
   always_comb begin
      prod    = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      exp_sum = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127
                + (prod[47] ? 10'sd1 : 10'sd0);
      sign    = a[31] ^ b[31];
      y       = 32'd0;
      u_flow  = 1'b0;
      o_flow  = 1'b0;
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) begin
         y = {sign, 31'd0};
      end else if (exp_sum >= 10'sd255) begin
         o_flow = 1'b1;
         y      = {sign, 8'hff, 23'd0};
      end else if (exp_sum <= 10'sd0) begin
         u_flow = 1'b1;
         y      = {sign, 31'd0};
      end else begin
         y = {sign, exp_sum[7:0], prod[47] ? prod[46:24] : prod[45:23]};
      end
   end

endmodule

// state | meaning
// IDLE  | waiting for a request, combinational grant drives reqN_ready
// BUSY  | operands latched, multiplier settling; result captured at end of cycle
// HOLD  | result presented on out_*, waiting for out_ready
module fp_mul_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   output logic             req1_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_id,
   output logic [31:0]      out_y,
   output logic             out_u_flow,
   output logic             out_o_flow,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1
);

   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

   state_t      state;
   logic        prio;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_id;

   logic        grant_vld;
   logic        grant_id;
   logic [31:0] mul_y;
   logic        mul_u_flow;
   logic        mul_o_flow;

   // Both requesting: priority bit decides; otherwise the lone requester wins.
   always_comb begin
      grant_vld  = req0_valid | req1_valid;
      grant_id   = (req0_valid & req1_valid) ? prio : req1_valid;
      req0_ready = (state == IDLE) && grant_vld && !grant_id;
      req1_ready = (state == IDLE) && grant_vld && grant_id;
   end

   floating_point_spmul u_mul (
      .a      (op_a),
      .b      (op_b),
      .y      (mul_y),
      .u_flow (mul_u_flow),
      .o_flow (mul_o_flow)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         prio       <= 1'b0;
         op_a       <= 32'd0;
         op_b       <= 32'd0;
         op_id      <= 1'b0;
         out_valid  <= 1'b0;
         out_id     <= 1'b0;
         out_y      <= 32'd0;
         out_u_flow <= 1'b0;
         out_o_flow <= 1'b0;
         done_cnt0  <= '0;
         done_cnt1  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  op_a  <= grant_id ? req1_a : req0_a;
                  op_b  <= grant_id ? req1_b : req0_b;
                  op_id <= grant_id;
                  prio  <= ~grant_id;
                  state <= BUSY;
               end
            end
            BUSY: begin
               out_y      <= mul_y;
               out_u_flow <= mul_u_flow;
               out_o_flow <= mul_o_flow;
               out_id     <= op_id;
               out_valid  <= 1'b1;
               state      <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
                  if (!out_id && done_cnt0 != '1)
                     done_cnt0 <= done_cnt0 + 1'b1;
                  if (out_id && done_cnt1 != '1)
                     done_cnt1 <= done_cnt1 + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed and randomized bench for fp_mul_arbiter, checked against a real-arithmetic
// reference of the multiply plus a simple grant/counter model.

module tb_fp_mul_arbiter;

   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req1_valid;
   logic [31:0]      req0_a, req0_b, req1_a, req1_b;
   logic             req0_ready, req1_ready;
   logic             out_valid, out_ready, out_id;
   logic [31:0]      out_y;
   logic             out_u_flow, out_o_flow;
   logic [CNT_W-1:0] done_cnt0, done_cnt1;

   int total = 0;
   int bad   = 0;

   int m_prio;
   int m_cnt0, m_cnt1;

   always #5 clk = ~clk;

   fp_mul_arbiter #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_id     (out_id),
      .out_y      (out_y),
      .out_u_flow (out_u_flow),
      .out_o_flow (out_o_flow),
      .done_cnt0  (done_cnt0),
      .done_cnt1  (done_cnt1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic real s2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:23] == 8'd0) return 0.0;
      d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // {u_flow, o_flow, y} from exact real multiplication (operands chosen so it is exact)
   function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      real         p;
      logic [63:0] d;
      logic        s;
      int          es;
      s = a[31] ^ b[31];
      p = s2r(a) * s2r(b);
      if (p == 0.0) return {2'b00, s, 31'd0};
      d  = $realtobits(p);
      es = int'(d[62:52]) - 896;
      if (es >= 255) return {2'b01, s, 8'hff, 23'd0};
      if (es <= 0)   return {2'b10, s, 31'd0};
      return {2'b00, s, es[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [7:0] e;
      logic [9:0] m;
      e = 8'($urandom_range(190, 64));
      m = 10'($urandom);
      if ($urandom_range(7, 0) == 0) return {1'($urandom), 31'd0};
      return {1'($urandom), e, m, 13'd0};
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_y"}, out_y, 32'd0);
      check({tag, "_id"}, 32'(out_id), 32'd0);
      check({tag, "_flags"}, {30'd0, out_u_flow, out_o_flow}, 32'd0);
      check({tag, "_cnt0"}, 32'(done_cnt0), 32'd0);
      check({tag, "_cnt1"}, 32'(done_cnt1), 32'd0);
   endtask

   // One full transaction; entered and left one time unit after a rising edge.
   task automatic run_op(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                         input int hold);
      int          eid;
      logic [33:0] r;
      logic [31:0] y_seen;
      eid = (v0 && v1) ? m_prio : (v1 ? 1 : 0);
      r   = (eid == 1) ? ref_mul(a1, b1) : ref_mul(a0, b0);
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      out_ready  = (hold == 0);
      #1;
      check("grant_ready0", 32'(req0_ready), 32'(eid == 0));
      check("grant_ready1", 32'(req1_ready), 32'(eid == 1));
      @(posedge clk); #1;
      m_prio = 1 - eid;
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      check("busy_valid", 32'(out_valid), 32'd0);
      check("busy_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      @(posedge clk); #1;
      check("res_valid", 32'(out_valid), 32'd1);
      check("res_id", 32'(out_id), 32'(eid));
      check("res_y", out_y, r[31:0]);
      check("res_flags", {30'd0, out_u_flow, out_o_flow}, {30'd0, r[33:32]});
      y_seen = out_y;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_y", out_y, y_seen);
         check("hold_id", 32'(out_id), 32'(eid));
         check("hold_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
         check("hold_cnt", {done_cnt1, done_cnt0}, 32'({m_cnt1[CNT_W-1:0], m_cnt0[CNT_W-1:0]}));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      if (eid == 0 && m_cnt0 < CNT_MAX) m_cnt0++;
      if (eid == 1 && m_cnt1 < CNT_MAX) m_cnt1++;
      check("done_valid", 32'(out_valid), 32'd0);
      check("done_cnt0", 32'(done_cnt0), 32'(m_cnt0));
      check("done_cnt1", 32'(done_cnt1), 32'(m_cnt1));
   endtask

   initial begin
      logic v0, v1;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      out_ready = 1'b0;
      m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      check("reset_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // 2.0 * 3.0 from req0 alone
      run_op(1'b1, 32'h4000_0000, 32'h4040_0000, 1'b0, 32'd0, 32'd0, 0);
      // dual requests: alternate grants, then priority back at req0
      run_op(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 32'h4080_0000, 0);
      run_op(1'b1, 32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 32'h4080_0000, 0);
      run_op(1'b1, 32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h4040_0000, 32'h4080_0000, 0);
      // overflow on req1, underflow on req0
      run_op(1'b0, 32'd0, 32'd0, 1'b1, 32'h7F00_0000, 32'h7F00_0000, 0);
      run_op(1'b1, 32'h0080_0000, 32'h0080_0000, 1'b0, 32'd0, 32'd0, 0);
      // backpressure with both requesters waiting
      run_op(1'b1, 32'h4100_0000, 32'h3F00_0000, 1'b1, 32'hC000_0000, 32'h4000_0000, 5);

      for (int n = 0; n < 24; n++) begin
         v0 = 1'($urandom);
         v1 = !v0 || 1'($urandom);
         run_op(v0, rnd_fp(), rnd_fp(), v1, rnd_fp(), rnd_fp(), int'($urandom_range(2, 0)));
      end

      // reset while BUSY
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'h4000_0000; req0_b = 32'h4000_0000;
      req1_a = 32'h4000_0000; req1_b = 32'h4000_0000;
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk) rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      @(negedge clk) rst = 1'b0;
      m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
      @(posedge clk); #1;
      run_op(1'b1, 32'h4040_0000, 32'h4040_0000, 1'b1, 32'h4080_0000, 32'h4080_0000, 0);

      // saturation: counters are CNT_W=2 bits wide
      for (int n = 0; n < 5; n++)
         run_op(1'b1, rnd_fp(), rnd_fp(), 1'b0, 32'd0, 32'd0, 0);
      check("sat_cnt0", 32'(done_cnt0), 32'(CNT_MAX));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
